// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, data word and memory arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  localparam word_t WORD_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous preload; used for the arbiter stall counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access, data first.
// Stall counters are built only when MEM_ARB_PERF_CNT_EN is defined; otherwise icount/dcount read 0.
module mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      ihit,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output word_t     icount,
  output word_t     dcount
);

  arb_state_t state_q;
  logic       dreq;

  assign dreq = dREN | dWEN;

  // A hit also requires the request to still be present, so a flush that
  // coincides with ACCESS never produces a completion.
  assign dhit  = (state_q == DGRANT) && (ramstate == ACCESS) && dreq;
  assign ihit  = (state_q == IGRANT) && (ramstate == ACCESS) && iREN;
  assign dload = dhit ? ramload : '0;
  assign iload = ihit ? ramload : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq) begin
            state_q <= DGRANT;
          end else if (iREN) begin
            state_q <= IGRANT;
          end
        end
        DGRANT: begin
          if (dhit || !dreq) begin
            state_q <= IDLE;
          end
        end
        IGRANT: begin
          if (ihit || !iREN) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // BUSY, FREE and ERROR all leave the grant in place so the request is retried.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

`ifdef MEM_ARB_PERF_CNT_EN
  sat_counter #(.WIDTH(32)) u_icount (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (iREN & ~ihit),
    .load_i     (1'b0),
    .load_val_i ('0),
    .count_o    (icount)
  );

  sat_counter #(.WIDTH(32)) u_dcount (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (dreq & ~dhit),
    .load_i     (1'b0),
    .load_val_i ('0),
    .count_o    (dcount)
  );
`else
  assign icount = '0;
  assign dcount = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; stall-counter checks follow MEM_ARB_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      RST;
  logic      iREN;
  word_t     iaddr;
  logic      ihit;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  word_t     icount;
  word_t     dcount;

  logic      sat_inc;
  logic      sat_load;
  word_t     sat_load_val;
  word_t     sat_count;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .icount(icount), .dcount(dcount)
  );

  sat_counter #(.WIDTH(32)) u_sat (
    .clk_i(CLK), .rst_i(RST), .inc_i(sat_inc), .load_i(sat_load),
    .load_val_i(sat_load_val), .count_o(sat_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    sat_inc = 1'b0; sat_load = 1'b0; sat_load_val = '0;
    #12;
    RST = 1'b0;
    #1;

    // Reset state
    check("rst_ramREN", {31'd0, ramREN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_icount", icount, 32'd0);
    check("rst_dcount", dcount, 32'd0);

    // Scenario 1: instruction fetch, ACCESS in the grant cycle
    tick();
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = FREE;
    #1 check("s1_idle_ramREN", {31'd0, ramREN}, 32'd0);
    tick();
    ramstate = ACCESS; ramload = 32'h2402_0005;
    #1 check("s1_ramREN", {31'd0, ramREN}, 32'd1);
    check("s1_ramaddr", ramaddr, 32'h0000_0040);
    check("s1_ihit", {31'd0, ihit}, 32'd1);
    check("s1_iload", iload, 32'h2402_0005);
    check("s1_dhit", {31'd0, dhit}, 32'd0);
    tick();
    iREN = 1'b0; ramstate = FREE;
    #1 check("s1_after_ihit", {31'd0, ihit}, 32'd0);
    check("s1_after_iload", iload, 32'd0);
    check("s1_after_ramREN", {31'd0, ramREN}, 32'd0);

    // Scenario 2: simultaneous fetch and load, data wins
    tick();
    iREN = 1'b1; iaddr = 32'h0000_0044; dREN = 1'b1; daddr = 32'h0000_0100;
    ramload = 32'hCAFE_0001;
    #1 check("s2_c1_ramREN", {31'd0, ramREN}, 32'd0);
    tick();
    ramstate = BUSY;
    #1 check("s2_c2_ramaddr", ramaddr, 32'h0000_0100);
    check("s2_c2_ramREN", {31'd0, ramREN}, 32'd1);
    check("s2_c2_hits", {30'd0, ihit, dhit}, 32'd0);
    tick();
    #1 check("s2_c3_hits", {30'd0, ihit, dhit}, 32'd0);
    tick();
    #1 check("s2_c4_ramaddr", ramaddr, 32'h0000_0100);
    tick();
    ramstate = ACCESS;
    #1 check("s2_c5_hits", {30'd0, ihit, dhit}, 32'd1);
    check("s2_c5_dload", dload, 32'hCAFE_0001);
    check("s2_c5_iload", iload, 32'd0);
    tick();
    dREN = 1'b0; ramstate = FREE; ramload = 32'h0000_1111;
    #1 check("s2_c6_idle_ramREN", {31'd0, ramREN}, 32'd0);
    check("s2_c6_hits", {30'd0, ihit, dhit}, 32'd0);
    tick();
    ramstate = ACCESS;
    #1 check("s2_c7_ramaddr", ramaddr, 32'h0000_0044);
    check("s2_c7_hits", {30'd0, ihit, dhit}, 32'd2);
    check("s2_c7_iload", iload, 32'h0000_1111);
    tick();
    idle_inputs();

    // Scenario 3: data write
    tick();
    dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'hDEAD_BEEF;
    tick();
    #1 check("s3_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("s3_ramREN", {31'd0, ramREN}, 32'd0);
    check("s3_ramstore", ramstore, 32'hDEAD_BEEF);
    check("s3_ramaddr", ramaddr, 32'h0000_0200);
    check("s3_dhit_free", {31'd0, dhit}, 32'd0);
    tick();
    ramstate = ACCESS;
    #1 check("s3_dhit", {31'd0, dhit}, 32'd1);
    tick();
    idle_inputs();
    #1 check("s3_after_ramWEN", {31'd0, ramWEN}, 32'd0);

    // Read and write together with an ERROR retry: write wins, no hit on ERROR
    tick();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0300; dstore = 32'h0000_00AA;
    tick();
    ramstate = ERROR;
    #1 check("rw_ramREN", {31'd0, ramREN}, 32'd0);
    check("rw_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("rw_err_dhit", {31'd0, dhit}, 32'd0);
    tick();
    #1 check("rw_err_retry_ramaddr", ramaddr, 32'h0000_0300);
    check("rw_err_retry_ramWEN", {31'd0, ramWEN}, 32'd1);
    tick();
    ramstate = ACCESS;
    #1 check("rw_dhit", {31'd0, dhit}, 32'd1);
    tick();
    idle_inputs();

    // Scenario 4: fetch flushed while BUSY, ACCESS arrives too late
    tick();
    iREN = 1'b1; iaddr = 32'h0000_0080;
    tick();
    ramstate = BUSY;
    #1 check("s4_grant_ramREN", {31'd0, ramREN}, 32'd1);
    tick();
    iREN = 1'b0; ramstate = ACCESS;
    #1 check("s4_flush_ihit", {31'd0, ihit}, 32'd0);
    tick();
    #1 check("s4_idle_ramREN", {31'd0, ramREN}, 32'd0);
    check("s4_idle_ihit", {31'd0, ihit}, 32'd0);
    idle_inputs();

    // Scenario 5: reset mid-DGRANT
    tick();
    dREN = 1'b1; daddr = 32'h0000_0400;
    tick();
    ramstate = BUSY;
    #1 check("s5_grant_ramREN", {31'd0, ramREN}, 32'd1);
    ramstate = ACCESS;
    RST = 1'b1;
    #1 check("s5_rst_ramREN", {31'd0, ramREN}, 32'd0);
    check("s5_rst_ramaddr", ramaddr, 32'd0);
    check("s5_rst_dhit", {31'd0, dhit}, 32'd0);
    check("s5_rst_dload", dload, 32'd0);
    dREN = 1'b0;
    #1 RST = 1'b0;
    #1 check("s5_rel_ramREN", {31'd0, ramREN}, 32'd0);
    tick();
    #1 check("s5_after_dhit", {31'd0, dhit}, 32'd0);
    check("s5_after_ramaddr", ramaddr, 32'd0);
    idle_inputs();

    // Scenario 6: stall counters
    do_reset();
    tick();
    iREN = 1'b1; iaddr = 32'h0000_0048; ramstate = BUSY;
    tick();
    tick();
    tick();
    ramstate = ACCESS;
    #1 check("s6_ihit", {31'd0, ihit}, 32'd1);
    tick();
    idle_inputs();
    #1;
`ifdef MEM_ARB_PERF_CNT_EN
    check("s6_icount", icount, 32'd3);
`else
    check("s6_icount_tied", icount, 32'd0);
`endif
    check("s6_dcount", dcount, 32'd0);

    // Saturation of a preloaded counter
    sat_load = 1'b1; sat_load_val = 32'hFFFF_FFFD;
    tick();
    sat_load = 1'b0; sat_inc = 1'b1;
    check("sat_load", sat_count, 32'hFFFF_FFFD);
    tick();
    check("sat_inc1", sat_count, 32'hFFFF_FFFE);
    tick();
    check("sat_inc2", sat_count, WORD_MAX);
    tick();
    check("sat_hold", sat_count, WORD_MAX);
    sat_inc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have these ports, clock and reset first: CLK  in  1  clock; all state on rising edge.
REQ-002 The module SHALL have RST  in  1  asynchronous reset, active-high.
REQ-003 The module SHALL have iREN  in  1  instruction-fetch read request, and iaddr  in  32  fetch address.
REQ-004 The module SHALL have ihit  out  1  fetch complete, and iload  out  32  fetched word.
REQ-005 The module SHALL have dREN  in  1  data read, dWEN  in  1  data write, daddr  in  32  data address, and dstore  in  32  write data.
REQ-006 The module SHALL have dhit  out  1  data access complete (the hit consumed by the hazard unit), and dload  out  32  loaded word.
REQ-007 The module SHALL have ramREN  out  1, ramWEN  out  1, ramaddr  out  32, ramstore  out  32, ramload  in  32, and ramstate  in  ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-008 The module SHALL have icount  out  32  fetch-stall cycles, and dcount  out  32  data-stall cycles.

Function
REQ-009 The FSM SHALL have states IDLE, DGRANT, IGRANT; reset state IDLE.
REQ-010 In IDLE, if dREN|dWEN, the next state SHALL be DGRANT; else if iREN, IGRANT; else IDLE. Data takes priority because its instruction is older.
REQ-011 In IDLE, all ram* outputs SHALL be 0.
REQ-012 In DGRANT, ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN.
REQ-013 In IGRANT, ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-014 dhit SHALL be 1 combinationally only when state=DGRANT and ramstate=ACCESS. ihit likewise for IGRANT.
REQ-015 dload and iload SHALL pass ramload through; each is valid only while its hit is high, and is 0 otherwise.
REQ-016 On a hit, the next state SHALL be IDLE; minimum latency is request to hit in 2 cycles (grant cycle, then ACCESS).
REQ-017 ihit and dhit SHALL never be high in the same cycle.
REQ-018 If the granted request deasserts before its hit (flush or redirect), the FSM SHALL return to IDLE next cycle and issue no hit.
REQ-019 If dREN and dWEN are both high, the write SHALL win: ramREN=0, ramWEN=1.
REQ-020 On ramstate=ERROR, the FSM SHALL hold state, keep driving the request (retry), and issue no hit.
REQ-021 While ramstate is BUSY or FREE, the FSM SHALL hold its state.
REQ-022 The datapath SHALL hold request inputs stable until the hit; the arbiter does not latch address or data.

Reset
REQ-023 Asserting RST SHALL force state IDLE immediately, with all outputs 0, including during a granted access. Any in-flight RAM access is abandoned, with no hit.
REQ-024 icount and dcount SHALL reset to 0.

Configuration
REQ-025 With MEM_ARB_PERF_CNT_EN defined, icount SHALL increment on every cycle with iREN=1 and ihit=0, and dcount on every cycle with (dREN|dWEN)=1 and dhit=0.
REQ-026 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-027 Without MEM_ARB_PERF_CNT_EN, the icount and dcount ports SHALL remain, tied to 0, and no counter flops SHALL be generated.

Structure
REQ-028 ramstate_t, word_t, and the arbiter state enum arb_state_t SHALL live in cpu_types_pkg.
REQ-029 The stall counters SHALL be one sub-module, sat_counter, instantiated twice under the macro; the FSM stays in mem_arbiter.

Verification
REQ-030 Scenario 1: iREN=1, iaddr=0x0000_0040, ramstate=ACCESS on the 2nd cycle, ramload=0x2402_0005 -> ihit for 1 cycle, iload=0x2402_0005, state IDLE after.
REQ-031 Scenario 2: iREN and dREN both high from IDLE, daddr=0x0000_0100, RAM BUSY for 3 cycles -> DGRANT first, dhit on cycle 5, then IGRANT, ihit 2 cycles later; never both hits in one cycle.
REQ-032 Scenario 3: dWEN=1, daddr=0x0000_0200, dstore=0xDEAD_BEEF -> ramWEN=1, ramREN=0, ramstore=0xDEAD_BEEF, dhit on ACCESS.
REQ-033 Scenario 4: IGRANT with BUSY, then iREN drops (flush) -> IDLE next cycle, no ihit, ramREN=0.
REQ-034 Scenario 5: RST pulsed mid-DGRANT -> all outputs 0 in the same cycle, IDLE after release, no dhit.
REQ-035 Scenario 6 (macro defined): iREN held 4 cycles with ihit on the 4th -> icount=3; counter preloaded near max -> holds at 0xFFFFFFFF.
